// File: rtl/onp_pkg.sv
// Shared types and defaults for the RPN token sequencer.
// ONP_ERR_SKIP_EN adds the DRAIN state used to swallow the rest of a bad expression.
package onp_pkg;

   localparam int W_DEF     = 16;
   localparam int CW_DEF    = 10;
   localparam int DEPTH_DEF = 1023;

   typedef enum logic [1:0] {
      TOK_NUM = 2'd0,
      TOK_OP  = 2'd1,
      TOK_END = 2'd2,
      TOK_CLR = 2'd3
   } tok_kind_e;

   typedef enum logic [1:0] {
      OP_PASS = 2'd0,
      OP_NEG  = 2'd1,
      OP_ADD  = 2'd2,
      OP_MUL  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_UNDER  = 2'd1,
      ERR_OVER   = 2'd2,
      ERR_BADEND = 2'd3
   } err_e;

`ifdef ONP_ERR_SKIP_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_SETUP, ST_STROBE, ST_SETTLE, ST_RESULT, ST_CLEAR, ST_DRAIN
   } state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_SETUP, ST_STROBE, ST_SETTLE, ST_RESULT, ST_CLEAR
   } state_e;
`endif

   // Number of stack entries an opcode consumes.
   function automatic int op_arity(input op_e op);
      return (op == OP_ADD || op == OP_MUL) ? 2 : 1;
   endfunction

endpackage

// File: rtl/onp_tok_check.sv
// Combinational stack-legality check of one token against the core's occupancy.
module onp_tok_check
   import onp_pkg::*;
#(
   parameter int CW    = CW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  tok_kind_e       kind,
   input  op_e             op,
   input  logic [CW-1:0]   cnt,
   output logic            ok,
   output err_e            err
);

   int cnt_i;
   assign cnt_i = int'(cnt);

   always_comb begin
      ok  = 1'b1;
      err = ERR_NONE;
      case (kind)
         TOK_NUM: if (cnt_i >= DEPTH) begin
            ok  = 1'b0;
            err = ERR_OVER;
         end
         TOK_OP: if (cnt_i < op_arity(op)) begin
            ok  = 1'b0;
            err = ERR_UNDER;
         end
         TOK_END: if (cnt_i != 1) begin
            ok  = 1'b0;
            err = ERR_BADEND;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/onp_seq_ctrl.sv
// Token sequencer driving the RPN stack core; one step strobe per legal token.
// Build with ONP_ERR_SKIP_EN to discard the remainder of an expression after an error.
module onp_seq_ctrl
   import onp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = W_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          tok_valid,
   output logic          tok_ready,
   input  logic [1:0]    tok_kind,
   input  logic [W-1:0]  tok_data,
   output logic          core_nrst,
   output logic          core_step,
   output logic          core_push,
   output logic [W-1:0]  core_d,
   output logic [1:0]    core_op,
   input  logic [W-1:0]  core_top,
   input  logic [CW-1:0] core_cnt,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [W-1:0]  res_data,
   output logic          res_err,
   output logic [1:0]    err_code,
   output logic          busy
);

   state_e         state_reg, state_next;
   tok_kind_e      kind_reg, kind_next;
   op_e            op_reg, op_next;
   logic           tok_ready_reg, tok_ready_next;
   logic           core_nrst_reg, core_nrst_next;
   logic           core_step_reg, core_step_next;
   logic           core_push_reg, core_push_next;
   logic [W-1:0]   core_d_reg, core_d_next;
   logic [1:0]     core_op_reg, core_op_next;
   logic           res_valid_reg, res_valid_next;
   logic [W-1:0]   res_data_reg, res_data_next;
   logic           res_err_reg, res_err_next;
   logic [1:0]     err_code_reg, err_code_next;
   logic           busy_reg, busy_next;
   logic           chk_ok;
   err_e           chk_err;
   logic           tok_fire;

   assign tok_fire = tok_valid && tok_ready_reg;

   onp_tok_check #(.CW(CW), .DEPTH(DEPTH)) u_check (
      .kind (kind_reg),
      .op   (op_reg),
      .cnt  (core_cnt),
      .ok   (chk_ok),
      .err  (chk_err)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (tok_fire) state_next = ST_SETUP;
         ST_SETUP: begin
            if (kind_reg == TOK_CLR)      state_next = ST_CLEAR;
            else if (kind_reg == TOK_END) state_next = ST_RESULT;
`ifdef ONP_ERR_SKIP_EN
            else if (!chk_ok)             state_next = ST_DRAIN;
`else
            else if (!chk_ok)             state_next = ST_RESULT;
`endif
            else                          state_next = ST_STROBE;
         end
         ST_STROBE: state_next = ST_SETTLE;
         ST_SETTLE: state_next = ST_IDLE;
         ST_RESULT: if (res_ready) state_next = ST_CLEAR;
         ST_CLEAR:  state_next = ST_IDLE;
`ifdef ONP_ERR_SKIP_EN
         ST_DRAIN: if (tok_fire) begin
            if (tok_kind_e'(tok_kind) == TOK_END)      state_next = ST_RESULT;
            else if (tok_kind_e'(tok_kind) == TOK_CLR) state_next = ST_CLEAR;
         end
`endif
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      kind_next      = kind_reg;
      op_next        = op_reg;
      core_push_next = core_push_reg;
      core_d_next    = core_d_reg;
      core_op_next   = core_op_reg;
      res_valid_next = res_valid_reg;
      res_data_next  = res_data_reg;
      res_err_next   = res_err_reg;
      err_code_next  = err_code_reg;
      core_step_next = (state_next == ST_STROBE);
      core_nrst_next = (state_next != ST_CLEAR);
      busy_next      = (state_next != ST_IDLE);
`ifdef ONP_ERR_SKIP_EN
      tok_ready_next = core_nrst_next && (state_next == ST_IDLE || state_next == ST_DRAIN);
`else
      tok_ready_next = core_nrst_next && (state_next == ST_IDLE);
`endif
      case (state_reg)
         ST_IDLE: if (tok_fire) begin
            kind_next      = tok_kind_e'(tok_kind);
            op_next        = op_e'(tok_data[1:0]);
            core_push_next = (tok_kind_e'(tok_kind) == TOK_NUM);
            core_d_next    = (tok_kind_e'(tok_kind) == TOK_NUM) ? tok_data : '0;
            core_op_next   = (tok_kind_e'(tok_kind) == TOK_OP) ? tok_data[1:0] : 2'd0;
         end
         ST_SETUP: begin
            // Only a legal NUM/OP keeps the drive lines for the strobe.
            if (state_next != ST_STROBE) begin
               core_push_next = 1'b0;
               core_d_next    = '0;
               core_op_next   = 2'd0;
            end
            if (state_next == ST_RESULT) begin
               res_valid_next = 1'b1;
               res_data_next  = chk_ok ? core_top : '0;
               res_err_next   = !chk_ok;
               err_code_next  = chk_err;
            end
`ifdef ONP_ERR_SKIP_EN
            if (state_next == ST_DRAIN) begin
               res_data_next = '0;
               res_err_next  = 1'b1;
               err_code_next = chk_err;
            end
`endif
         end
         ST_STROBE: begin
            core_push_next = 1'b0;
            core_d_next    = '0;
            core_op_next   = 2'd0;
         end
         ST_RESULT: if (res_ready) res_valid_next = 1'b0;
`ifdef ONP_ERR_SKIP_EN
         ST_DRAIN: if (state_next == ST_RESULT) res_valid_next = 1'b1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         kind_reg      <= TOK_NUM;
         op_reg        <= OP_PASS;
         tok_ready_reg <= 1'b0;
         core_nrst_reg <= 1'b0;
         core_step_reg <= 1'b0;
         core_push_reg <= 1'b0;
         core_d_reg    <= '0;
         core_op_reg   <= 2'd0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
         res_err_reg   <= 1'b0;
         err_code_reg  <= 2'd0;
         busy_reg      <= 1'b0;
      end else begin
         kind_reg      <= kind_next;
         op_reg        <= op_next;
         tok_ready_reg <= tok_ready_next;
         core_nrst_reg <= core_nrst_next;
         core_step_reg <= core_step_next;
         core_push_reg <= core_push_next;
         core_d_reg    <= core_d_next;
         core_op_reg   <= core_op_next;
         res_valid_reg <= res_valid_next;
         res_data_reg  <= res_data_next;
         res_err_reg   <= res_err_next;
         err_code_reg  <= err_code_next;
         busy_reg      <= busy_next;
      end
   end

   assign tok_ready = tok_ready_reg;
   assign core_nrst = core_nrst_reg;
   assign core_step = core_step_reg;
   assign core_push = core_push_reg;
   assign core_d    = core_d_reg;
   assign core_op   = core_op_reg;
   assign res_valid = res_valid_reg;
   assign res_data  = res_data_reg;
   assign res_err   = res_err_reg;
   assign err_code  = err_code_reg;
   assign busy      = busy_reg;

endmodule
